sad_accum_4b: RTL and testbench

SAD_ACCUM_4B -- requirements
Module: sad_accum_4b

---
 rtl/sad_accum_4b_pkg.sv | 17 +
 rtl/sad_accum_4b_if.sv | 26 ++
 rtl/sad_accum_4b_abs_diff.sv | 11 +
 rtl/sad_accum_4b.sv | 97 +++++++++
 tb/tb_sad_accum_4b.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/sad_accum_4b_pkg.sv
// Shared types and limits for the SAD accumulator: FSM state encoding and
// the saturation ceilings of the sum and pair-count registers.
package sad_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  localparam int unsigned DIFF_W = 4;
  localparam int unsigned SUM_W  = 8;
  localparam int unsigned CNT_W  = 5;

  localparam logic [SUM_W-1:0] SUM_MAX = 8'd255;
  localparam logic [CNT_W-1:0] CNT_MAX = 5'd31;

endpackage

// File: rtl/sad_accum_4b_if.sv
// Handshake bundle for the SAD accumulator: an input-pair stream with a frame
// marker and a per-frame result stream.
interface sad_accum_4b_if;

  logic       in_val;
  logic       in_rdy;
  logic [3:0] in0;
  logic [3:0] in1;
  logic       in_last;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out_sum;
  logic [4:0] out_cnt;
  logic       out_sat;

  modport master (
    output in_val, in0, in1, in_last, out_rdy,
    input  in_rdy, out_val, out_sum, out_cnt, out_sat
  );

  modport slave (
    input  in_val, in0, in1, in_last, out_rdy,
    output in_rdy, out_val, out_sum, out_cnt, out_sat
  );

endinterface

// File: rtl/sad_accum_4b_abs_diff.sv
// Combinational unsigned absolute difference of two 4-bit operands; the
// result always fits in 4 bits (0..15).
module abs_diff_4b (
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  output logic [3:0] diff
);

  assign diff = (in0 >= in1) ? (in0 - in1) : (in1 - in0);

endmodule

// File: rtl/sad_accum_4b.sv
// Frame-based sum of absolute differences: accumulates |in0-in1| per accepted
// pair and presents a saturated sum, saturated pair count and sticky flag.
module sad_accum_4b
  import sad_accum_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  sad_accum_4b_if.slave   bus
);

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic               in_rdy;
  logic               out_val;
  logic               in_fire_p0;
  logic               out_fire;
  logic [DIFF_W-1:0]  diff_p0;
  logic [SUM_W:0]     add_res;

  // Returns {overflow, sum}; an add that would pass SUM_MAX pins at SUM_MAX.
  function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0] acc,
                                             input logic [DIFF_W-1:0] mag);
    logic [SUM_W:0] wide;
    wide = {1'b0, acc} + {{(SUM_W+1-DIFF_W){1'b0}}, mag};
    if (wide > {1'b0, SUM_MAX}) return {1'b1, SUM_MAX};
    return {1'b0, wide[SUM_W-1:0]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_MAX) return CNT_MAX;
    return cnt + 5'd1;
  endfunction

  abs_diff_4b u_abs_diff (
    .in0  (bus.in0),
    .in1  (bus.in1),
    .diff (diff_p0)
  );

  assign in_rdy     = (state_q == ACCUM);
  assign out_val    = (state_q == DONE);
  assign in_fire_p0 = bus.in_val & in_rdy;
  assign out_fire   = out_val & bus.out_rdy;
  assign add_res    = sat_add(sum_q, diff_p0);

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    unique case (state_q)
      ACCUM: begin
        if (in_fire_p0) begin
          sum_d = add_res[SUM_W-1:0];
          sat_d = sat_q | add_res[SUM_W];
          cnt_d = sat_inc(cnt_q);
          if (bus.in_last) state_d = DONE;
        end
      end
      DONE: begin
        // Result is held until taken; clearing here makes every frame start at zero.
        if (out_fire) begin
          state_d = ACCUM;
          sum_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Stage p0 -> registered frame state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      sum_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.in_rdy  = in_rdy;
  assign bus.out_val = out_val;
  assign bus.out_sum = sum_q;
  assign bus.out_cnt = cnt_q;
  assign bus.out_sat = sat_q;

endmodule

// File: tb/tb_sad_accum_4b.sv
// Directed self-checking bench for sad_accum_4b with hand-computed results.
module tb_sad_accum_4b;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sad_accum_4b_if bus ();

  sad_accum_4b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pair(input logic [3:0] a, input logic [3:0] b, input logic last);
    @(negedge clk);
    bus.in_val  = 1'b1;
    bus.in0     = a;
    bus.in1     = b;
    bus.in_last = last;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_val  = 1'b0;
    bus.in_last = 1'b0;
  endtask

  // Called at a negedge while in DONE: accept the result over one edge.
  task automatic take();
    bus.out_rdy = 1'b1;
    @(negedge clk);
    bus.out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got %0d want 1", bus.in_rdy); end
    checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val got %0d want 0", bus.out_val); end
    checks++; if (bus.out_sum !== 8'd0) begin errors++; $display("FAIL reset_sum got %0d want 0", bus.out_sum); end
    checks++; if (bus.out_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.out_cnt); end
    checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %0d want 0", bus.out_sat); end
  endtask

  // Pair is presented together with reset release, so the first edge must take it.
  task automatic test_single_pair();
    rst_n       = 1'b1;
    bus.in_val  = 1'b1;
    bus.in0     = 4'd3;
    bus.in1     = 4'd10;
    bus.in_last = 1'b1;
    idle();
    checks++; if (bus.out_val !== 1'b1) begin errors++; $display("FAIL single_out_val got %0d want 1", bus.out_val); end
    checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL single_in_rdy got %0d want 0", bus.in_rdy); end
    checks++; if (bus.out_sum !== 8'd7) begin errors++; $display("FAIL single_sum got %0d want 7", bus.out_sum); end
    checks++; if (bus.out_cnt !== 5'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", bus.out_cnt); end
    checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL single_sat got %0d want 0", bus.out_sat); end
    take();
    checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL single_taken_val got %0d want 0", bus.out_val); end
    checks++; if (bus.out_sum !== 8'd0) begin errors++; $display("FAIL single_cleared_sum got %0d want 0", bus.out_sum); end
  endtask

  task automatic test_back_to_back();
    pair(4'd1, 4'd1, 1'b0);
    pair(4'd9, 4'd2, 1'b0);
    checks++; if (bus.out_sum !== 8'd0) begin errors++; $display("FAIL b2b_running_sum got %0d want 0", bus.out_sum); end
    pair(4'd0, 4'd15, 1'b0);
    checks++; if (bus.out_sum !== 8'd7) begin errors++; $display("FAIL b2b_running_sum2 got %0d want 7", bus.out_sum); end
    pair(4'd15, 4'd0, 1'b1);
    idle();
    checks++; if (bus.out_val !== 1'b1) begin errors++; $display("FAIL b2b_out_val got %0d want 1", bus.out_val); end
    checks++; if (bus.out_sum !== 8'd37) begin errors++; $display("FAIL b2b_sum got %0d want 37", bus.out_sum); end
    checks++; if (bus.out_cnt !== 5'd4) begin errors++; $display("FAIL b2b_cnt got %0d want 4", bus.out_cnt); end
    checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL b2b_sat got %0d want 0", bus.out_sat); end
    take();
    checks++; if (bus.out_cnt !== 5'd0) begin errors++; $display("FAIL b2b_cleared_cnt got %0d want 0", bus.out_cnt); end
  endtask

  task automatic test_backpressure();
    pair(4'd5, 4'd2, 1'b0);
    pair(4'd2, 4'd5, 1'b1);
    idle();
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_val  = 1'b1;
      bus.in0     = 4'($urandom_range(0, 15));
      bus.in1     = 4'($urandom_range(0, 15));
      bus.in_last = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy[%0d] got %0d want 0", i, bus.in_rdy); end
      checks++; if (bus.out_val !== 1'b1) begin errors++; $display("FAIL bp_out_val[%0d] got %0d want 1", i, bus.out_val); end
      checks++; if (bus.out_sum !== 8'd6) begin errors++; $display("FAIL bp_sum[%0d] got %0d want 6", i, bus.out_sum); end
      checks++; if (bus.out_cnt !== 5'd2) begin errors++; $display("FAIL bp_cnt[%0d] got %0d want 2", i, bus.out_cnt); end
      checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL bp_sat[%0d] got %0d want 0", i, bus.out_sat); end
    end
    bus.in_val  = 1'b0;
    bus.in_last = 1'b0;
    take();
    // in_last without in_val must not end the frame
    bus.in_last = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL bp_stray_last got %0d want 0", bus.out_val); end
    pair(4'd6, 4'd1, 1'b0);
    pair(4'd7, 4'd7, 1'b1);
    idle();
    checks++; if (bus.out_sum !== 8'd5) begin errors++; $display("FAIL bp_next_sum got %0d want 5", bus.out_sum); end
    checks++; if (bus.out_cnt !== 5'd2) begin errors++; $display("FAIL bp_next_cnt got %0d want 2", bus.out_cnt); end
    take();
  endtask

  task automatic test_sum_saturation();
    for (int i = 0; i < 17; i++) pair(4'd0, 4'd15, 1'b0);
    idle();
    checks++; if (bus.out_sum !== 8'd255) begin errors++; $display("FAIL sat_exact_sum got %0d want 255", bus.out_sum); end
    checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL sat_exact_flag got %0d want 0", bus.out_sat); end
    pair(4'd0, 4'd15, 1'b1);
    idle();
    checks++; if (bus.out_sum !== 8'd255) begin errors++; $display("FAIL sat_sum got %0d want 255", bus.out_sum); end
    checks++; if (bus.out_sat !== 1'b1) begin errors++; $display("FAIL sat_flag got %0d want 1", bus.out_sat); end
    checks++; if (bus.out_cnt !== 5'd18) begin errors++; $display("FAIL sat_cnt got %0d want 18", bus.out_cnt); end
    take();
    checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL sat_cleared got %0d want 0", bus.out_sat); end
  endtask

  task automatic test_cnt_saturation();
    for (int i = 0; i < 34; i++) pair(4'd2, 4'd1, 1'b0);
    pair(4'd2, 4'd1, 1'b1);
    idle();
    checks++; if (bus.out_cnt !== 5'd31) begin errors++; $display("FAIL cnt_sat_cnt got %0d want 31", bus.out_cnt); end
    checks++; if (bus.out_sum !== 8'd35) begin errors++; $display("FAIL cnt_sat_sum got %0d want 35", bus.out_sum); end
    checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL cnt_sat_flag got %0d want 0", bus.out_sat); end
    take();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) pair(4'd7, 4'd2, 1'b0);
    idle();
    checks++; if (bus.out_sum !== 8'd15) begin errors++; $display("FAIL ar_partial_sum got %0d want 15", bus.out_sum); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_sum !== 8'd0) begin errors++; $display("FAIL ar_sum got %0d want 0", bus.out_sum); end
    checks++; if (bus.out_cnt !== 5'd0) begin errors++; $display("FAIL ar_cnt got %0d want 0", bus.out_cnt); end
    checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL ar_in_rdy got %0d want 1", bus.in_rdy); end
    @(negedge clk);
    rst_n = 1'b1;
    pair(4'd4, 4'd1, 1'b1);
    idle();
    checks++; if (bus.out_sum !== 8'd3) begin errors++; $display("FAIL ar_new_sum got %0d want 3", bus.out_sum); end
    checks++; if (bus.out_cnt !== 5'd1) begin errors++; $display("FAIL ar_new_cnt got %0d want 1", bus.out_cnt); end
    // Reset while a result is pending drops it.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL ar_done_val got %0d want 0", bus.out_val); end
    checks++; if (bus.out_sum !== 8'd0) begin errors++; $display("FAIL ar_done_sum got %0d want 0", bus.out_sum); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.in_val  = 1'b0;
    bus.in0     = 4'd0;
    bus.in1     = 4'd0;
    bus.in_last = 1'b0;
    bus.out_rdy = 1'b0;
    test_reset();
    test_single_pair();
    test_back_to_back();
    test_backpressure();
    test_sum_saturation();
    test_cnt_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
